// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the single Bridge bus.
// One transaction in flight at a time, with a slave timeout that error-terminates it.
module bus_arbiter #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_wen,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_wen,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        Bus_req,
  output logic [31:0] Bus_addr,
  output logic        Bus_wen,
  output logic [31:0] Bus_wdata,
  input  logic        Bus_ack,
  input  logic [31:0] Bus_rdata,
  output logic [1:0]  grant
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // 0 = M0, 1 = M1
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_wen_q, bus_wen_d;
  logic        m0_ack_q, m0_ack_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic        m0_err_q, m0_err_d;
  logic        m1_ack_q, m1_ack_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        m1_err_q, m1_err_d;

  logic        win_s;
  logic        done_s;
  logic [31:0] rdata_s;
  logic        err_s;

  // On contention the master that did not own the bus last time wins.
  assign win_s = (m0_req & m1_req) ? ~last_q : m1_req;

  // Next-state logic; output registers are derived from the next state so they change with it.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    m0_rdata_d = m0_rdata_q;
    m0_err_d   = m0_err_q;
    m1_rdata_d = m1_rdata_q;
    m1_err_d   = m1_err_q;
    done_s     = 1'b0;
    rdata_s    = Bus_rdata;
    err_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_req | m1_req) begin
          owner_d = win_s;
          addr_d  = win_s ? m1_addr : m0_addr;
          wen_d   = win_s ? m1_wen : m0_wen;
          wdata_d = win_s ? m1_wdata : m0_wdata;
          grant_d = win_s ? 2'b10 : 2'b01;
          cnt_d   = '0;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Bus_ack wins over a timeout hitting in the same cycle.
        if (Bus_ack) begin
          done_s  = 1'b1;
          rdata_s = Bus_rdata;
          err_s   = 1'b0;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LIM)) begin
          done_s  = 1'b1;
          rdata_s = ERR_DATA;
          err_s   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (done_s) begin
          state_d = ST_RESP;
          if (owner_q) begin
            m1_rdata_d = rdata_s;
            m1_err_d   = err_s;
          end else begin
            m0_rdata_d = rdata_s;
            m0_err_d   = err_s;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RESP: begin
        last_d  = owner_q;
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
    endcase

    bus_req_d = (state_d == ST_REQ);
    bus_wen_d = (state_d == ST_REQ) & wen_d;
    m0_ack_d  = (state_d == ST_RESP) & ~owner_d;
    m1_ack_d  = (state_d == ST_RESP) & owner_d;
  end

  // State and output registers; reset aborts any transaction without acking it.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      addr_q     <= 32'h0000_0000;
      wen_q      <= 1'b0;
      wdata_q    <= 32'h0000_0000;
      cnt_q      <= '0;
      grant_q    <= 2'b00;
      bus_req_q  <= 1'b0;
      bus_wen_q  <= 1'b0;
      m0_ack_q   <= 1'b0;
      m0_rdata_q <= 32'h0000_0000;
      m0_err_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m1_rdata_q <= 32'h0000_0000;
      m1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      bus_req_q  <= bus_req_d;
      bus_wen_q  <= bus_wen_d;
      m0_ack_q   <= m0_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m0_err_q   <= m0_err_d;
      m1_ack_q   <= m1_ack_d;
      m1_rdata_q <= m1_rdata_d;
      m1_err_q   <= m1_err_d;
    end
  end

  assign Bus_req   = bus_req_q;
  assign Bus_addr  = addr_q;
  assign Bus_wen   = bus_wen_q;
  assign Bus_wdata = wdata_q;
  assign grant     = grant_q;
  assign m0_ack    = m0_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m0_err    = m0_err_q;
  assign m1_ack    = m1_ack_q;
  assign m1_rdata  = m1_rdata_q;
  assign m1_err    = m1_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (default TIMEOUT=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bus_arbiter;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        m0_req, m0_wen, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_wen, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        Bus_req, Bus_wen, Bus_ack;
  logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
  logic [1:0]  grant;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 cpu_clk = ~cpu_clk;

  bus_arbiter dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .Bus_req(Bus_req), .Bus_addr(Bus_addr), .Bus_wen(Bus_wen), .Bus_wdata(Bus_wdata),
    .Bus_ack(Bus_ack), .Bus_rdata(Bus_rdata), .grant(grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge cpu_clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"},   {31'd0, Bus_req}, 32'd0);
    chk({tag, "_bus_addr"},  Bus_addr, 32'd0);
    chk({tag, "_bus_wen"},   {31'd0, Bus_wen}, 32'd0);
    chk({tag, "_bus_wdata"}, Bus_wdata, 32'd0);
    chk({tag, "_m0_ack"},    {31'd0, m0_ack}, 32'd0);
    chk({tag, "_m0_rdata"},  m0_rdata, 32'd0);
    chk({tag, "_m0_err"},    {31'd0, m0_err}, 32'd0);
    chk({tag, "_m1_ack"},    {31'd0, m1_ack}, 32'd0);
    chk({tag, "_m1_rdata"},  m1_rdata, 32'd0);
    chk({tag, "_m1_err"},    {31'd0, m1_err}, 32'd0);
    chk({tag, "_grant"},     {30'd0, grant}, 32'd0);
  endtask

  logic [1:0]  g_exp  [8] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
  logic        a0_exp [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        a1_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] ad_exp [8] = '{32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h2000_0000,
                              32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h1000_0000};

  initial begin
    cpu_rst = 1'b0;
    m0_req = 1'b0; m0_addr = 32'd0; m0_wen = 1'b0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_addr = 32'd0; m1_wen = 1'b0; m1_wdata = 32'd0;
    Bus_ack = 1'b0; Bus_rdata = 32'd0;

    tick;
    chk_all_zero("rst");
    cpu_rst = 1'b1;
    tick;
    chk("idle_grant", {30'd0, grant}, 32'd0);

    // Single M0 read, acked in the first REQ cycle
    m0_req = 1'b1; m0_addr = 32'h8000_0010; m0_wen = 1'b0;
    tick;
    chk("t1_bus_req", {31'd0, Bus_req}, 32'd1);
    chk("t1_grant", {30'd0, grant}, 32'd1);
    chk("t1_addr", Bus_addr, 32'h8000_0010);
    chk("t1_wen", {31'd0, Bus_wen}, 32'd0);
    chk("t1_ack_early", {31'd0, m0_ack}, 32'd0);
    Bus_ack = 1'b1; Bus_rdata = 32'h1234_5678;
    tick;
    chk("t1_ack", {31'd0, m0_ack}, 32'd1);
    chk("t1_rdata", m0_rdata, 32'h1234_5678);
    chk("t1_err", {31'd0, m0_err}, 32'd0);
    chk("t1_bus_req_drop", {31'd0, Bus_req}, 32'd0);
    chk("t1_m1_ack", {31'd0, m1_ack}, 32'd0);
    m0_req = 1'b0; Bus_ack = 1'b0; Bus_rdata = 32'd0;
    tick;
    chk("t1_ack_once", {31'd0, m0_ack}, 32'd0);
    chk("t1_grant_idle", {30'd0, grant}, 32'd0);
    chk("t1_rdata_hold", m0_rdata, 32'h1234_5678);
    chk("t1_addr_hold", Bus_addr, 32'h8000_0010);

    // Single M1 write, slave waits 4 cycles
    m1_req = 1'b1; m1_addr = 32'h4000_0020; m1_wen = 1'b1; m1_wdata = 32'hA5A5_0001;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t2_bus_req", {31'd0, Bus_req}, 32'd1);
      chk("t2_bus_wen", {31'd0, Bus_wen}, 32'd1);
      chk("t2_addr", Bus_addr, 32'h4000_0020);
      chk("t2_wdata", Bus_wdata, 32'hA5A5_0001);
      chk("t2_grant", {30'd0, grant}, 32'd2);
      chk("t2_ack_early", {31'd0, m1_ack}, 32'd0);
      if (i == 4) Bus_ack = 1'b1;
    end
    tick;
    chk("t2_ack", {31'd0, m1_ack}, 32'd1);
    chk("t2_err", {31'd0, m1_err}, 32'd0);
    chk("t2_bus_req_drop", {31'd0, Bus_req}, 32'd0);
    chk("t2_bus_wen_drop", {31'd0, Bus_wen}, 32'd0);
    chk("t2_m0_ack", {31'd0, m0_ack}, 32'd0);
    m1_req = 1'b0; Bus_ack = 1'b0;
    tick;
    chk("t2_ack_once", {31'd0, m1_ack}, 32'd0);

    // Contention from reset; Bus_ack held high, also while not in REQ
    cpu_rst = 1'b0;
    tick;
    cpu_rst = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h1000_0000; m0_wen = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h2000_0000; m1_wen = 1'b0;
    Bus_ack = 1'b1; Bus_rdata = 32'h0000_00C3;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("t3_grant", {30'd0, grant}, {30'd0, g_exp[i]});
      chk("t3_m0_ack", {31'd0, m0_ack}, {31'd0, a0_exp[i]});
      chk("t3_m1_ack", {31'd0, m1_ack}, {31'd0, a1_exp[i]});
      chk("t3_addr", Bus_addr, ad_exp[i]);
    end
    m0_req = 1'b0; m1_req = 1'b0; Bus_ack = 1'b0;
    tick;
    chk("t3_m1_rdata", m1_rdata, 32'h0000_00C3);
    chk("t3_grant_idle", {30'd0, grant}, 32'd0);

    // Timeout: no Bus_ack, then an M1 read goes through normally
    m0_req = 1'b1; m0_addr = 32'h8000_0100; m0_wen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick;
      chk("t4_bus_req", {31'd0, Bus_req}, 32'd1);
      chk("t4_ack_early", {31'd0, m0_ack}, 32'd0);
    end
    tick;
    chk("t4_bus_req_drop", {31'd0, Bus_req}, 32'd0);
    chk("t4_ack", {31'd0, m0_ack}, 32'd1);
    chk("t4_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("t4_err", {31'd0, m0_err}, 32'd1);
    m0_req = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h2000_0040; m1_wen = 1'b0;
    tick;
    chk("t4_idle_grant", {30'd0, grant}, 32'd0);
    tick;
    chk("t4_m1_grant", {30'd0, grant}, 32'd2);
    chk("t4_m1_bus_req", {31'd0, Bus_req}, 32'd1);
    Bus_ack = 1'b1; Bus_rdata = 32'h0BAD_F00D;
    tick;
    chk("t4_m1_ack", {31'd0, m1_ack}, 32'd1);
    chk("t4_m1_rdata", m1_rdata, 32'h0BAD_F00D);
    chk("t4_m1_err", {31'd0, m1_err}, 32'd0);
    chk("t4_m0_rdata_hold", m0_rdata, 32'hDEAD_BEEF);
    chk("t4_m0_err_hold", {31'd0, m0_err}, 32'd1);
    m1_req = 1'b0; Bus_ack = 1'b0;
    tick;

    // Bus_ack on the last allowed REQ cycle counts as success
    m0_req = 1'b1; m0_addr = 32'h8000_0200; m0_wen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick;
      chk("t5_bus_req", {31'd0, Bus_req}, 32'd1);
      if (i == 15) begin
        Bus_ack = 1'b1; Bus_rdata = 32'h0000_0042;
      end
    end
    tick;
    chk("t5_ack", {31'd0, m0_ack}, 32'd1);
    chk("t5_err", {31'd0, m0_err}, 32'd0);
    chk("t5_rdata", m0_rdata, 32'h0000_0042);
    m0_req = 1'b0; Bus_ack = 1'b0;
    tick;
    chk("t5_ack_once", {31'd0, m0_ack}, 32'd0);

    // Reset in the middle of an M1 write
    m1_req = 1'b1; m1_addr = 32'h2000_0080; m1_wen = 1'b1; m1_wdata = 32'h1111_2222;
    tick;
    chk("t6_bus_req", {31'd0, Bus_req}, 32'd1);
    chk("t6_bus_wen", {31'd0, Bus_wen}, 32'd1);
    chk("t6_grant", {30'd0, grant}, 32'd2);
    #2 cpu_rst = 1'b0;
    #1 chk_all_zero("t6_async");
    tick;
    chk_all_zero("t6_held");
    cpu_rst = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h8000_0300; m0_wen = 1'b0;
    tick;
    chk("t6_grant_m0", {30'd0, grant}, 32'd1);
    chk("t6_addr_m0", Bus_addr, 32'h8000_0300);
    chk("t6_wen_m0", {31'd0, Bus_wen}, 32'd0);
    chk("t6_m1_ack", {31'd0, m1_ack}, 32'd0);
    Bus_ack = 1'b1; Bus_rdata = 32'h5555_AAAA;
    tick;
    chk("t6_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("t6_m0_rdata", m0_rdata, 32'h5555_AAAA);
    chk("t6_m1_ack_loser", {31'd0, m1_ack}, 32'd0);
    m0_req = 1'b0; Bus_ack = 1'b0;
    tick;
    chk("t6_idle_grant", {30'd0, grant}, 32'd0);
    tick;
    chk("t6_grant_m1", {30'd0, grant}, 32'd2);
    chk("t6_m1_wen", {31'd0, Bus_wen}, 32'd1);
    Bus_ack = 1'b1;
    tick;
    chk("t6_m1_ack_final", {31'd0, m1_ack}, 32'd1);
    m1_req = 1'b0; Bus_ack = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
